// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: N-bit operands, 2N-bit product, unsigned or
// two's-complement per operation, fixed N+1 cycle latency with start/done handshake.
module seq_mul #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]  LAST_CNT = CW'(N);
  localparam logic [2*N-1:0] ONE_2N   = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]   ONE_N    = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]     state_q,  state_d;
  logic [CW-1:0]  count_q,  count_d;
  logic [2*N-1:0] acc_q,    acc_d;
  logic [2*N-1:0] mcand_q,  mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic           neg_q,    neg_d;
  logic [2*N-1:0] p_q,      p_d;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           capture;

  // The most negative operand negates to 2^(N-1), which is still exact as N-bit unsigned.
  always_comb begin
    a_mag = (sgn && a[N-1]) ? (~a + ONE_N) : a;
    b_mag = (sgn && b[N-1]) ? (~b + ONE_N) : b;
  end

  assign capture = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    p_d      = p_q;

    if (capture) begin
      state_d  = S_RUN;
      count_d  = '0;
      acc_d    = '0;
      mcand_d  = {{N{1'b0}}, a_mag};
      mplier_d = b_mag;
      neg_d    = sgn && (a[N-1] ^ b[N-1]);
    end else begin
      case (state_q)
        S_RUN: begin
          if (count_q == LAST_CNT) begin
            // All N iterations are in the accumulator; apply the sign and publish.
            p_d     = neg_q ? (~acc_q + ONE_2N) : acc_q;
            state_d = S_DONE;
          end else begin
            if (mplier_q[0]) begin
              acc_d = acc_q + mcand_q;
            end
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            count_d  = count_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul at N=4 and N=8: directed table, handshake and
// reset corner sequences, and randomized operations against an arithmetic model.
module tb_seq_mul;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0, sgn4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [7:0] p4;

  logic       start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [15:0] p8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_mul #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  seq_mul #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  typedef struct {
    bit          w8;
    bit          s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Product from plain integer arithmetic, truncated to the 2N-bit result width.
  function automatic logic [15:0] ref_mul(input bit w8, input bit s,
                                          input logic [7:0] a, input logic [7:0] b);
    int     w;
    longint va, vb, prod;
    w  = w8 ? 8 : 4;
    va = longint'(a) & ((longint'(1) << w) - 1);
    vb = longint'(b) & ((longint'(1) << w) - 1);
    if (s && va >= (longint'(1) << (w - 1))) va -= (longint'(1) << w);
    if (s && vb >= (longint'(1) << (w - 1))) vb -= (longint'(1) << w);
    prod = va * vb;
    return 16'(prod & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic cur_done(input bit w8);
    return w8 ? done8 : done4;
  endfunction

  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy4;
  endfunction

  function automatic logic [15:0] cur_p(input bit w8);
    return w8 ? p8 : {8'h00, p4};
  endfunction

  // Presents start for exactly one edge (edge 0) and returns #1 after it.
  task automatic issue(input bit w8, input bit s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    end else begin
      start4 = 1'b1; sgn4 = s; a4 = a[3:0]; b4 = b[3:0];
    end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Edges counted from the capture edge; returns 99 if done never arrives.
  task automatic wait_done(input bit w8, output int k);
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (cur_done(w8)) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_op(input bit w8, input bit s, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input string name);
    int k;
    issue(w8, s, a, b);
    check({name, "_busy"}, 32'(cur_busy(w8)), 32'd1);
    wait_done(w8, k);
    check({name, "_lat"}, 32'(k), w8 ? 32'd9 : 32'd5);
    check({name, "_p"}, 32'(cur_p(w8)), 32'(exp));
  endtask

  vec_t vecs[$];

  initial begin
    int k;
    int dcount;
    logic [7:0]  ra, rb;
    bit          rs;

    vecs.push_back('{1'b0, 1'b0, 8'd1,   8'd1,   16'd1});
    vecs.push_back('{1'b0, 1'b0, 8'd15,  8'd14,  16'd210});
    vecs.push_back('{1'b0, 1'b0, 8'd15,  8'd15,  16'd225});
    vecs.push_back('{1'b0, 1'b0, 8'd0,   8'd9,   16'd0});
    vecs.push_back('{1'b0, 1'b1, 8'h08,  8'h08,  16'h0040});
    vecs.push_back('{1'b0, 1'b1, 8'h0D,  8'h05,  16'h00F1});
    vecs.push_back('{1'b0, 1'b1, 8'h07,  8'h0F,  16'h00F9});
    vecs.push_back('{1'b1, 1'b0, 8'd255, 8'd255, 16'd65025});
    vecs.push_back('{1'b1, 1'b1, 8'h80,  8'h7F,  16'hC080});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_p4",    32'(p4),    32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_p8",    32'(p8),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].w8, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p,
             $sformatf("vec%0d", i));
    end

    // Handshake: start during RUN is ignored; start in DONE restarts at once.
    issue(1'b0, 1'b0, 8'd3, 8'd2);
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
      end
      if (i == 3) begin
        start4 = 1'b0;
      end
      if (done4) begin
        k = i;
        break;
      end
    end
    check("hs_lat1", 32'(k), 32'd5);
    check("hs_p1",   32'(p4), 32'd6);
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd2;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check("hs_no_gap", 32'(busy4), 32'd1);
    check("hs_p_hold", 32'(p4), 32'd6);
    wait_done(1'b0, k);
    check("hs_lat2", 32'(k), 32'd5);
    check("hs_p2",   32'(p4), 32'd4);

    // Reset on the second RUN cycle aborts the operation.
    issue(1'b0, 1'b0, 8'd15, 8'd14);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_p",    32'(p4),    32'd0);
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done4) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    run_op(1'b0, 1'b0, 8'd2, 8'd3, 16'd6, "after_abort");

    // Randomized operations, both widths.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 2 == 0) begin
        ra[7:4] = 4'h0;
        rb[7:4] = 4'h0;
        run_op(1'b0, rs, ra, rb, ref_mul(1'b0, rs, ra, rb), $sformatf("rnd4_%0d", i));
      end else begin
        run_op(1'b1, rs, ra, rb, ref_mul(1'b1, rs, ra, rb), $sformatf("rnd8_%0d", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
